seven_seg_scan_ctrl: RTL and testbench



---
 rtl/seven_seg_scan_ctrl_pkg.sv | 23 ++
 rtl/seven_seg_scan_ctrl_lut.sv | 40 ++++
 rtl/seven_seg_scan_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_pkg
//  Purpose  : Shared constants and state encoding for the seven-segment
//             scan controller.
//  Revision : 1.0  initial release
// ============================================================================
package seven_seg_pkg;

   // Width of one hex digit.
   localparam int NIBBLE_W = 4;

   // All segments and the decimal point dark (outputs are active-low).
   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Digit-slot phases: anti-ghosting blank interval, then the lit digit.
   typedef enum logic [0:0] {
      S_BLANK = 1'b0,
      S_SHOW  = 1'b1
   } scan_state_t;

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl_lut.sv
`default_nettype none
// ============================================================================
//  Module   : SEVEN_SEGMENT_LUT
//  Purpose  : Hex nibble to seven-segment pattern, active-low,
//             bit order {a,b,c,d,e,f,g,dp}; dp is always returned dark.
//  Revision : 1.0  initial release
// ============================================================================
module SEVEN_SEGMENT_LUT
   import seven_seg_pkg::*;
(
   input  logic [NIBBLE_W-1:0] nibble,
   output logic [7:0]          seg
);

   // Pure lookup; patterns written active-high then inverted for the pins.
   always_comb begin
      seg = SEG_OFF;
      case (nibble)
         4'h0:    seg = ~8'b1111_1100;
         4'h1:    seg = ~8'b0110_0000;
         4'h2:    seg = ~8'b1101_1010;
         4'h3:    seg = ~8'b1111_0010;
         4'h4:    seg = ~8'b0110_0110;
         4'h5:    seg = ~8'b1011_0110;
         4'h6:    seg = ~8'b1011_1110;
         4'h7:    seg = ~8'b1110_0000;
         4'h8:    seg = ~8'b1111_1110;
         4'h9:    seg = ~8'b1111_0110;
         4'hA:    seg = ~8'b1110_1110;
         4'hB:    seg = ~8'b0011_1110;
         4'hC:    seg = ~8'b1001_1100;
         4'hD:    seg = ~8'b0111_1010;
         4'hE:    seg = ~8'b1001_1110;
         4'hF:    seg = ~8'b1000_1110;
         default: seg = SEG_OFF;
      endcase
   end

endmodule : SEVEN_SEGMENT_LUT
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for a common-enable
//             seven-segment display with double-buffered value.
//  Options  : define LEADING_ZERO_BLANK_EN to blank leading zero digits.
//  Revision : 1.0  initial release
// ============================================================================
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS = 3,
   parameter int SCAN_DIV   = 12000,
   parameter int BLANK_CYC  = 64
) (
   input  logic                           iCLK,
   input  logic                           iRST_N,
   input  logic                           iEN,
   input  logic [NIBBLE_W*NUM_DIGITS-1:0] iVALUE,
   input  logic [NUM_DIGITS-1:0]          iDP,
   input  logic                           iLOAD,
   output logic                           oPENDING,
   output logic                           oFRAME,
   output logic [7:0]                     oSEG,
   output logic [NUM_DIGITS-1:0]          oEN
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
   localparam int VAL_W = NIBBLE_W * NUM_DIGITS;

   localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] EN_OFF     = '1;
   localparam logic [NUM_DIGITS-1:0] EN_ONE     = NUM_DIGITS'(1);

   scan_state_t           state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [IDX_W-1:0]      idx, idx_nxt;

   logic [VAL_W-1:0]      shadow_val, shadow_val_nxt, active_val, active_val_nxt;
   logic [NUM_DIGITS-1:0] shadow_dp, shadow_dp_nxt, active_dp, active_dp_nxt;
   logic                  pending_nxt;

   logic                  slot_start, frame_start;
   logic [NIBBLE_W-1:0]   lut_nibble;
   logic [7:0]            lut_seg, seg_nxt;
   logic [NUM_DIGITS-1:0] en_nxt, lz_blank;
   logic                  digit_blank;

   // Scan position registers: phase, cycle-in-slot and digit index.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state <= S_BLANK;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
      end
   end

   // Next scan position; disabling parks the scanner at the start of a frame.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      if (!iEN) begin
         state_nxt = S_BLANK;
         cnt_nxt   = '0;
         idx_nxt   = '0;
      end else begin
         cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
         case (state)
            S_BLANK: if (cnt == BLANK_LAST) state_nxt = S_SHOW;
            S_SHOW: begin
               if (cnt == CNT_LAST) begin
                  state_nxt = S_BLANK;
                  idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
               end
            end
            default: state_nxt = S_BLANK;
         endcase
      end
   end

   // Shadow/active buffering; a load on the commit cycle bypasses the shadow.
   always_comb begin
      slot_start     = iEN && (cnt == '0);
      frame_start    = slot_start && (idx == '0);
      shadow_val_nxt = shadow_val;
      shadow_dp_nxt  = shadow_dp;
      active_val_nxt = active_val;
      active_dp_nxt  = active_dp;
      pending_nxt    = oPENDING;
      if (frame_start && iLOAD) begin
         active_val_nxt = iVALUE;
         active_dp_nxt  = iDP;
         pending_nxt    = 1'b0;
      end else begin
         if (frame_start && oPENDING) begin
            active_val_nxt = shadow_val;
            active_dp_nxt  = shadow_dp;
            pending_nxt    = 1'b0;
         end
         if (iLOAD) begin
            shadow_val_nxt = iVALUE;
            shadow_dp_nxt  = iDP;
            pending_nxt    = 1'b1;
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Blank every digit whose nibble and all higher nibbles are zero; digit 0 never.
   always_comb begin : lz_scan
      logic zero_run;
      zero_run = 1'b1;
      lz_blank = '0;
      for (int d = NUM_DIGITS - 1; d > 0; d--) begin
         zero_run    = zero_run && (active_val_nxt[d*NIBBLE_W +: NIBBLE_W] == '0);
         lz_blank[d] = zero_run;
      end
   end
`else
   // Every digit is always shown.
   always_comb lz_blank = '0;
`endif

   // Lookup uses the post-commit value so a new frame shows fresh data at once.
   always_comb begin
      lut_nibble  = active_val_nxt[NIBBLE_W*int'(idx) +: NIBBLE_W];
      digit_blank = lz_blank[idx];
   end

   SEVEN_SEGMENT_LUT u_lut (
      .nibble (lut_nibble),
      .seg    (lut_seg)
   );

   // Output pattern: segment bits latched once per slot, enables follow the phase.
   always_comb begin
      seg_nxt = oSEG;
      en_nxt  = EN_OFF;
      if (!iEN) begin
         seg_nxt = SEG_OFF;
      end else begin
         if (slot_start) begin
            seg_nxt = {lut_seg[7:1] | {7{digit_blank}},
                       lut_seg[0] & ~active_dp_nxt[idx]};
         end
         if (state == S_SHOW) en_nxt = ~(EN_ONE << idx);
      end
   end

   // Data buffers and registered display outputs.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         shadow_val <= '0;
         shadow_dp  <= '0;
         active_val <= '0;
         active_dp  <= '0;
         oPENDING   <= 1'b0;
         oFRAME     <= 1'b0;
         oSEG       <= SEG_OFF;
         oEN        <= EN_OFF;
      end else begin
         shadow_val <= shadow_val_nxt;
         shadow_dp  <= shadow_dp_nxt;
         active_val <= active_val_nxt;
         active_dp  <= active_dp_nxt;
         oPENDING   <= pending_nxt;
         oFRAME     <= frame_start;
         oSEG       <= seg_nxt;
         oEN        <= en_nxt;
      end
   end

endmodule : seven_seg_scan_ctrl
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_seven_seg_scan_ctrl
//  Purpose  : Scoreboard bench for seven_seg_scan_ctrl (3 digits, 8-cycle
//             slots, 2 blank cycles).  Honours LEADING_ZERO_BLANK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;

   localparam int ND = 3;
   localparam int SD = 8;
   localparam int BC = 2;
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [11:0] value = '0;
   logic [2:0]  dp = '0;
   logic        pending, frame;
   logic [7:0]  seg;
   logic [2:0]  den;

   typedef struct {
      logic [2:0] en;
      logic [7:0] seg;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   seven_seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .iCLK     (clk),
      .iRST_N   (rst_n),
      .iEN      (en),
      .iVALUE   (value),
      .iDP      (dp),
      .iLOAD    (load),
      .oPENDING (pending),
      .oFRAME   (frame),
      .oSEG     (seg),
      .oEN      (den)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Hand-written segment table (active-high abcdefg), then inverted.
   function automatic logic [7:0] exp_seg(input logic [11:0] v, input logic [2:0] d, input int dig);
      logic [3:0] n;
      logic [6:0] s;
      logic       zero_above;
      n = v[dig*4 +: 4];
      case (n)
         4'h0: s = 7'b1111110;  4'h1: s = 7'b0110000;
         4'h2: s = 7'b1101101;  4'h3: s = 7'b1111001;
         4'h4: s = 7'b0110011;  4'h5: s = 7'b1011011;
         4'h6: s = 7'b1011111;  4'h7: s = 7'b1110000;
         4'h8: s = 7'b1111111;  4'h9: s = 7'b1111011;
         4'hA: s = 7'b1110111;  4'hB: s = 7'b0011111;
         4'hC: s = 7'b1001110;  4'hD: s = 7'b0111101;
         4'hE: s = 7'b1001111;  default: s = 7'b1000111;
      endcase
      zero_above = 1'b1;
      for (int k = dig; k < ND; k++)
         if (v[k*4 +: 4] != 4'h0) zero_above = 1'b0;
      if (LZB && dig > 0 && zero_above) s = 7'b0;
      return ~{s, d[dig]};
   endfunction

   task automatic push_frame(input logic [11:0] v, input logic [2:0] d);
      exp_t e;
      for (int k = 0; k < ND; k++) begin
         e.en  = ~(3'b001 << k);
         e.seg = exp_seg(v, d, k);
         q.push_back(e);
      end
   endtask

   task automatic wait_frame();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 80 && !seen; i++) begin
         @(negedge clk);
         if (frame) seen = 1'b1;
      end
      chk("frame_seen", 32'(seen), 32'd1);
      if (seen) chk("pending_clear_at_frame", 32'(pending), 32'd0);
   endtask

   task automatic frame_and_push(input logic [11:0] v, input logic [2:0] d);
      wait_frame();
      push_frame(v, d);
   endtask

   task automatic do_load(input logic [11:0] v, input logic [2:0] d);
      @(posedge clk);
      #1 value = v; dp = d; load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   task automatic wait_show();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (den != 3'b111) seen = 1'b1;
      end
      chk("show_seen", 32'(seen), 32'd1);
   endtask

   // Monitor: pops one expectation at the start of each lit phase and checks
   // the blank lead-in, enable, pattern, lit length and pattern stability.
   int         blank_cnt = 0;
   int         show_len = 0;
   bit         prev_show = 1'b0;
   bit         track = 1'b0;
   bit         seg_stable = 1'b1;
   logic [7:0] held_seg = '0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         blank_cnt = 0; show_len = 0; prev_show = 1'b0; track = 1'b0;
      end else if (den == 3'b111) begin
         if (prev_show && track) begin
            chk("show_len", 32'(show_len), 32'(SD - BC));
            chk("seg_stable", 32'(seg_stable), 32'd1);
            track = 1'b0;
         end
         if (frame || prev_show) blank_cnt = 1;
         else blank_cnt++;
         prev_show = 1'b0;
      end else begin
         if (!prev_show) begin
            show_len   = 1;
            seg_stable = 1'b1;
            held_seg   = seg;
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("slot_en", 32'(den), 32'(e.en));
               chk("slot_seg", 32'(seg), 32'(e.seg));
               chk("blank_len", 32'(blank_cnt), 32'(BC));
               track = 1'b1;
            end
         end else begin
            show_len++;
            if (seg != held_seg) seg_stable = 1'b0;
         end
         prev_show = 1'b1;
      end
   end

   initial begin
      // 1. reset state, then free-running scan of the reset value
      repeat (3) @(posedge clk);
      #1;
      chk("rst_seg", 32'(seg), 32'hFF);
      chk("rst_en", 32'(den), 32'h7);
      chk("rst_frame", 32'(frame), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      en = 1'b1;
      rst_n = 1'b1;
      frame_and_push(12'h000, 3'b000);

      // 2. mid-frame load commits at the next frame only
      repeat (5) @(posedge clk);
      do_load(12'h1A3, 3'b000);
      chk("pending_after_load", 32'(pending), 32'd1);
      frame_and_push(12'h1A3, 3'b000);

      // 3. last of two loads wins; a load on the commit edge bypasses shadow
      repeat (3) @(posedge clk);
      do_load(12'h111, 3'b000);
      do_load(12'h222, 3'b000);
      chk("pending_two_loads", 32'(pending), 32'd1);
      frame_and_push(12'h222, 3'b000);
      repeat (SD*ND - 1) @(posedge clk);
      #1 value = 12'h3C5; dp = 3'b000; load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
      frame_and_push(12'h3C5, 3'b000);

      // 4. decimal point on the middle digit
      do_load(12'h888, 3'b010);
      frame_and_push(12'h888, 3'b010);

      // 5. disable mid-slot, load while dark, re-enable
      wait_frame();
      wait_show();
      @(posedge clk);
      #1 en = 1'b0;
      @(posedge clk);
      #1;
      chk("dis_en", 32'(den), 32'h7);
      chk("dis_seg", 32'(seg), 32'hFF);
      chk("dis_frame", 32'(frame), 32'd0);
      do_load(12'h456, 3'b000);
      chk("dis_pending", 32'(pending), 32'd1);
      repeat (4) @(posedge clk);
      #1 en = 1'b1;
      frame_and_push(12'h456, 3'b000);

      // asynchronous reset in the middle of a lit slot drops pending data
      wait_frame();
      do_load(12'h777, 3'b101);
      wait_show();
      #3 rst_n = 1'b0;
      #1;
      chk("arst_seg", 32'(seg), 32'hFF);
      chk("arst_en", 32'(den), 32'h7);
      chk("arst_pending", 32'(pending), 32'd0);
      chk("arst_frame", 32'(frame), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      frame_and_push(12'h000, 3'b000);

      // 6. leading-zero patterns
      do_load(12'h005, 3'b000);
      frame_and_push(12'h005, 3'b000);
      do_load(12'h000, 3'b000);
      frame_and_push(12'h000, 3'b000);

      // drain the scoreboard
      for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
      repeat (SD + 2) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_seven_seg_scan_ctrl
`default_nettype wire
